cariomart_button_uart_tx: RTL and testbench

CARIOMART_BUTTON_UART_TX -- requirements
Module: cariomart_button_uart_tx

---
 rtl/cariomart_pkg.sv | 9 +
 rtl/cariomart_debounce.sv | 27 ++
 rtl/cariomart_button_uart_tx.sv | 109 ++++++++++
 tb/tb_cariomart_button_uart_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cariomart_pkg.sv
// cariomart_pkg: shared FSM encoding, frame header and byte-count helper
`timescale 1ns/1ps
package cariomart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam logic [7:0] HEADER = 8'hA5;
  function automatic int nbytes(input int n);
    return (n + 7) / 8;
  endfunction
endpackage

// File: rtl/cariomart_debounce.sv
// cariomart_debounce: 2-flop synchronizer plus stable-count debounce, one channel
`timescale 1ns/1ps
module cariomart_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic FAB_CLK,
  input  logic FAB_RESET_N,
  input  logic btn,
  output logic state,
  output logic toggle
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // toggle is the cycle whose edge flips state, so callers see it alongside the change
  assign toggle = (sync[1] != state) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge FAB_CLK)
    if (!FAB_RESET_N) begin
      sync  <= '0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      cnt   <= (sync[1] == state || toggle) ? '0 : cnt + 1'b1;
      state <= state ^ toggle;
    end
endmodule

// File: rtl/cariomart_button_uart_tx.sv
// cariomart_button_uart_tx: debounced buttons reported as 8N1 UART frames on change
`timescale 1ns/1ps
module cariomart_button_uart_tx
  import cariomart_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BAUD_DIV        = 347
) (
  input  logic                   FAB_CLK,
  input  logic                   FAB_RESET_N,
  input  logic [NUM_BUTTONS-1:0] BTN_IN,
  input  logic                   ENABLE,
  output logic                   UART_TXD,
  output logic [NUM_BUTTONS-1:0] BTN_STATE,
  output logic                   BUSY,
  output logic                   FRAME_SENT
);
  localparam int NB = nbytes(NUM_BUTTONS);
  localparam int SW = 8 * NB;
  localparam int IW = $clog2(NB + 2);
  localparam int BW = $clog2(BAUD_DIV);
  logic [NUM_BUTTONS-1:0] toggles;
  tx_state_e state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [IW-1:0] byte_idx, byte_n;
  logic [SW-1:0] snap, snap_n;
  logic pending, pending_n;
  logic [7:0] csum, cur;
  logic [SW+15:0] frame;
  logic baud_end, last_byte;
  genvar i;
  generate
    for (i = 0; i < NUM_BUTTONS; i++) begin : g_db
      cariomart_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .FAB_CLK    (FAB_CLK),
        .FAB_RESET_N(FAB_RESET_N),
        .btn        (BTN_IN[i]),
        .state      (BTN_STATE[i]),
        .toggle     (toggles[i])
      );
    end
  endgenerate
  always_comb begin
    csum = HEADER;
    for (int k = 0; k < NB; k++) csum = csum ^ snap[8*k +: 8];
  end
  // byte 0 is the header, the checksum sits just past the last data byte
  assign frame      = {csum, snap, HEADER};
  assign cur        = frame[{byte_idx, 3'b000} +: 8];
  assign baud_end   = baud_cnt == BW'(BAUD_DIV - 1);
  assign last_byte  = byte_idx == IW'(NB + 1);
  assign UART_TXD   = (state == START) ? 1'b0 : (state == DATA) ? cur[bit_idx] : 1'b1;
  assign BUSY       = state != IDLE;
  assign FRAME_SENT = (state == STOP) && baud_end && last_byte;
  always_ff @(posedge FAB_CLK)
    if (!FAB_RESET_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      snap     <= snap_n;
      pending  <= pending_n;
    end
  always_comb begin
    state_n   = state;
    baud_n    = '0;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    snap_n    = snap;
    pending_n = pending | (|toggles);
    if (state == IDLE) begin
      bit_n  = '0;
      byte_n = '0;
      // a change landing on the start edge stays pending for the next frame
      if (pending && ENABLE) begin
        state_n   = START;
        snap_n    = SW'(BTN_STATE);
        pending_n = |toggles;
      end
    end else begin
      baud_n = baud_end ? '0 : baud_cnt + 1'b1;
      if (baud_end) begin
        case (state)
          START: begin
            state_n = DATA;
            bit_n   = '0;
          end
          DATA: begin
            bit_n   = bit_idx + 3'd1;
            state_n = (bit_idx == 3'd7) ? STOP : DATA;
          end
          default: begin
            state_n = last_byte ? IDLE : START;
            byte_n  = last_byte ? '0 : byte_idx + 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cariomart_button_uart_tx.sv
// tb_cariomart_button_uart_tx: directed vector bench for the button UART framer
`timescale 1ns/1ps
module tb_cariomart_button_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] BTN_IN = 2'b00;
  logic ENABLE = 1'b1;
  logic UART_TXD, BUSY, FRAME_SENT;
  logic [1:0] BTN_STATE;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cariomart_button_uart_tx #(.NUM_BUTTONS(2), .DEBOUNCE_CYCLES(4), .BAUD_DIV(4)) dut (
    .FAB_CLK    (clk),
    .FAB_RESET_N(rst_n),
    .BTN_IN     (BTN_IN),
    .ENABLE     (ENABLE),
    .UART_TXD   (UART_TXD),
    .BTN_STATE  (BTN_STATE),
    .BUSY       (BUSY),
    .FRAME_SENT (FRAME_SENT)
  );

  typedef struct {
    logic [1:0] btn;
    logic [1:0] st;
    logic [7:0] data;
    logic [7:0] csum;
  } vec_t;
  vec_t tv [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic watch_idle(input string nm, input int n, input logic [1:0] st);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (UART_TXD !== 1'b1 || BUSY !== 1'b0 || FRAME_SENT !== 1'b0 || BTN_STATE !== st) bad++;
    end
    chk(nm, bad, 0);
  endtask

  task automatic press(input string nm, input logic [1:0] b, input logic [1:0] st);
    int n = 0;
    @(posedge clk);
    #1 BTN_IN = b;
    do begin
      @(posedge clk);
      #1 n++;
    end while (BTN_STATE !== st && n < 20);
    chk({nm, "_latency"}, n, 6);
    chk({nm, "_state"}, BTN_STATE, st);
  endtask

  task automatic rx_frame(input int mid_c, input logic [1:0] mid_btn, output int wait_n,
                          output logic [23:0] by, output logic ok, output int fs_c, output logic busy_ok);
    int bi, k;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (UART_TXD !== 1'b0 && wait_n < 400);
    by = '0;
    ok = (UART_TXD === 1'b0);
    fs_c = -1;
    busy_ok = 1'b1;
    for (int c = 0; c <= 120; c++) begin
      if (c > 0) @(negedge clk);
      if (c == mid_c) BTN_IN = mid_btn;
      if (c % 4 == 2 && c < 120) begin
        bi = c / 40;
        k = (c % 40) / 4;
        if (k == 0) ok = ok & (UART_TXD === 1'b0);
        else if (k == 9) ok = ok & (UART_TXD === 1'b1);
        else by[8*bi + k - 1] = UART_TXD;
      end
      if (FRAME_SENT === 1'b1 && fs_c < 0) fs_c = c;
      if (BUSY !== (c < 120)) busy_ok = 1'b0;
    end
  endtask

  task automatic frame_check(input string nm, input int mid_c, input logic [1:0] mid_btn,
                             input int exp_wait, input logic [7:0] d, input logic [7:0] cs);
    int w, fs;
    logic [23:0] by;
    logic ok, bo;
    rx_frame(mid_c, mid_btn, w, by, ok, fs, bo);
    chk({nm, "_start_wait"}, w, exp_wait);
    chk({nm, "_header"}, by[7:0], 8'hA5);
    chk({nm, "_data"}, by[15:8], d);
    chk({nm, "_csum"}, by[23:16], cs);
    chk({nm, "_framing"}, ok, 1);
    chk({nm, "_frame_sent_cycle"}, fs, 119);
    chk({nm, "_busy"}, bo, 1);
  endtask

  initial begin
    tv[0] = '{2'b00, 2'b01, 8'h01, 8'hA4};
    tv[1] = '{2'b00, 2'b11, 8'h03, 8'hA6};
    tv[2] = '{2'b00, 2'b10, 8'h02, 8'hA7};
    tv[3] = '{2'b00, 2'b00, 8'h00, 8'hA5};
    for (int i = 0; i < 4; i++) tv[i].btn = tv[i].st;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", UART_TXD, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_frame_sent", FRAME_SENT, 0);
    chk("rst_btn_state", BTN_STATE, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    watch_idle("idle_after_reset", 200, 2'b00);

    for (int i = 0; i < 4; i++) begin
      press($sformatf("vec%0d", i), tv[i].btn, tv[i].st);
      frame_check($sformatf("vec%0d", i), -1, 2'b00, 2, tv[i].data, tv[i].csum);
    end

    @(posedge clk);
    #1 BTN_IN = 2'b10;
    repeat (3) @(posedge clk);
    #1 BTN_IN = 2'b00;
    watch_idle("glitch", 60, 2'b00);

    press("b2b_a", 2'b01, 2'b01);
    frame_check("b2b_a", 45, 2'b11, 2, 8'h01, 8'hA4);
    frame_check("b2b_b", -1, 2'b11, 1, 8'h03, 8'hA6);

    press("both_release", 2'b00, 2'b00);
    frame_check("both_release", -1, 2'b00, 2, 8'h00, 8'hA5);

    ENABLE = 1'b0;
    press("en_off", 2'b01, 2'b01);
    watch_idle("en_off_hold", 50, 2'b01);
    @(posedge clk);
    #1 ENABLE = 1'b1;
    frame_check("en_on", -1, 2'b00, 2, 8'h01, 8'hA4);

    press("rst_mid", 2'b00, 2'b00);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (UART_TXD !== 1'b0 && n < 20);
      chk("rst_mid_started", UART_TXD, 0);
    end
    repeat (10) @(posedge clk);
    #1 chk("rst_mid_busy_before", BUSY, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_txd", UART_TXD, 1);
    chk("rst_mid_busy", BUSY, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    watch_idle("after_mid_reset", 200, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
